// File: rtl/sorted_loader.sv
// Insertion-sorting loader: keeps up to DEPTH values ascending in a register array behind a
// 1-cycle read port. Optional duplicate discard is enabled by defining SORTED_LOADER_DEDUP_EN.
module sorted_loader #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] q,
  output logic             Busy,
  output logic             Full,
  output logic [CW-1:0]    Count,
  output logic             Drop
);

  typedef enum logic [1:0] {StIdle, StScan, StShift} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_p;
  logic [CW-1:0]    r_j;
  logic [CW-1:0]    r_count;
  logic             r_drop;

  logic             w_full;
  logic             w_accept;
  logic             w_reject;
  logic [WIDTH-1:0] w_mem_p;
  logic             w_scan_stop;
  logic             w_shift_more;
  logic [AW-1:0]    w_jm1;
  logic             w_dup;
  logic             w_drop;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_accept     = (r_state == StIdle) && !Clear && Load && !w_full;
  assign w_reject     = (r_state == StIdle) && !Clear && Load && w_full;
  assign w_mem_p      = r_mem[r_p[AW-1:0]];
  assign w_scan_stop  = (r_p == r_count) || (w_mem_p > r_d);
  assign w_shift_more = (r_j > r_p);
  assign w_jm1        = r_j[AW-1:0] - 1'b1;

`ifdef SORTED_LOADER_DEDUP_EN
  // Scan runs past equal entries, so a duplicate is the last entry passed before the stop point.
  logic r_eq;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_eq <= 1'b0;
    end else if (w_accept) begin
      r_eq <= 1'b0;
    end else if (r_state == StScan && !w_scan_stop) begin
      r_eq <= (w_mem_p == r_d);
    end
  end

  assign w_dup = (r_state == StScan) && w_scan_stop && r_eq;
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StScan;
      StScan: begin
        if (w_dup) begin
          w_state_next = StIdle;
        end else if (w_scan_stop) begin
          w_state_next = StShift;
        end
      end
      StShift: if (!w_shift_more) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    Busy   = (r_state != StIdle);
    Full   = w_full;
    Count  = r_count;
    q      = r_q;
    Drop   = r_drop;
    w_drop = w_reject || w_dup;
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_d     <= '0;
      r_p     <= '0;
      r_j     <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_drop  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_q    <= r_mem[rd_addr];
      r_drop <= w_drop;
      unique case (r_state)
        StIdle: begin
          if (Clear) begin
            r_count <= '0;
          end else if (w_accept) begin
            r_d <= Din;
            r_p <= '0;
          end
        end
        StScan: begin
          if (!w_scan_stop) begin
            r_p <= r_p + 1'b1;
          end else begin
            r_j <= r_count;
          end
        end
        StShift: begin
          // Open a hole at P by moving the tail up one slot, top entry first.
          if (w_shift_more) begin
            r_mem[r_j[AW-1:0]] <= r_mem[w_jm1];
            r_j                <= r_j - 1'b1;
          end else begin
            r_mem[r_p[AW-1:0]] <= r_d;
            r_count            <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_loader.sv
// Directed plus randomized bench for sorted_loader, checked against a sorted-queue model.
// Honours SORTED_LOADER_DEDUP_EN the same way as the design.
module tb_sorted_loader;

  localparam int DEPTH = 32;
`ifdef SORTED_LOADER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       Reset;
  logic       Load;
  logic [7:0] Din;
  logic       Clear;
  logic [4:0] rd_addr;
  logic [7:0] q;
  logic       Busy;
  logic       Full;
  logic [5:0] Count;
  logic       Drop;

  int n_tests = 0;
  int n_fail  = 0;
  int model[$];

  sorted_loader dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .Load     (Load),
    .Din      (Din),
    .Clear    (Clear),
    .rd_addr  (rd_addr),
    .q        (q),
    .Busy     (Busy),
    .Full     (Full),
    .Count    (Count),
    .Drop     (Drop)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int n_le(input int v);
    int n = 0;
    foreach (model[i]) if (model[i] <= v) n++;
    return n;
  endfunction

  function automatic bit has_eq(input int v);
    foreach (model[i]) if (model[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Called on a falling edge with Busy low; returns on the falling edge after Busy drops.
  task automatic do_load(input logic [7:0] v);
    int exp_busy, busy_n, n;
    bit exp_drop, ins, drop_seen;
    n = model.size();
    if (n == DEPTH) begin
      exp_busy = 0; exp_drop = 1'b1; ins = 1'b0;
    end else if (DEDUP && has_eq(v)) begin
      exp_busy = n_le(v) + 1; exp_drop = 1'b1; ins = 1'b0;
    end else begin
      exp_busy = n + 2; exp_drop = 1'b0; ins = 1'b1;
    end
    Load = 1'b1;
    Din  = v;
    @(negedge CLOCK_50);
    Load = 1'b0;
    busy_n    = 0;
    drop_seen = 1'b0;
    while (Busy === 1'b1 && busy_n < 200) begin
      if (Drop === 1'b1) drop_seen = 1'b1;
      busy_n++;
      @(negedge CLOCK_50);
    end
    if (Drop === 1'b1) drop_seen = 1'b1;
    chk("busy_len", busy_n, exp_busy);
    chk("drop", drop_seen, exp_drop);
    if (ins) model.insert(n_le(v), v);
    chk("count", Count, model.size());
    chk("full", Full, model.size() == DEPTH);
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < model.size(); i++) begin
      rd_addr = 5'(i);
      @(negedge CLOCK_50);
      chk(tag, q, model[i]);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge CLOCK_50);
    Reset = 1'b0;
    model.delete();
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    @(negedge CLOCK_50);
    Clear = 1'b0;
    model.delete();
    chk("clear_count", Count, 0);
    chk("clear_full", Full, 1'b0);
  endtask

  initial begin
    int cyc, n;
    bit drop_seen;
    Reset = 1'b1; Load = 1'b0; Clear = 1'b0; Din = '0; rd_addr = '0;
    repeat (2) @(negedge CLOCK_50);
    chk("rst_q", q, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_full", Full, 0);
    chk("rst_count", Count, 0);
    chk("rst_drop", Drop, 0);
    Reset = 1'b0;
    rd_addr = 5'd7;
    @(negedge CLOCK_50);
    chk("rst_mem", q, 0);

    // Basic three-value load
    do_load(8'd50);
    do_load(8'd10);
    do_load(8'd30);
    check_array("basic_q");

    // Descending fill to full, then overflow
    do_reset();
    for (int v = 255; v >= 224; v--) do_load(8'(v));
    chk("fill_full", Full, 1'b1);
    check_array("fill_q");
    do_load(8'd99);
    do_clear();

    // Duplicate handling
    do_load(8'd7);
    do_load(8'd7);
    check_array("dup_q");

    // Reset in the middle of a shift
    do_clear();
    do_load(8'd40);
    do_load(8'd60);
    do_load(8'd80);
    Load = 1'b1; Din = 8'd20;
    @(negedge CLOCK_50);
    Load = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("mid_busy", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_count", Count, 0);
    chk("abort_q", q, 0);
    @(negedge CLOCK_50);
    Reset = 1'b0;
    model.delete();
    rd_addr = 5'd0;
    @(negedge CLOCK_50);
    chk("abort_read", q, 0);
    do_load(8'd5);
    check_array("abort_q5");

    // Load held and Clear pulsed while busy
    do_load(8'd12);
    do_load(8'd3);
    n = model.size();
    Load = 1'b1; Din = 8'd9;
    @(negedge CLOCK_50);
    cyc = 0;
    drop_seen = 1'b0;
    while (Busy === 1'b1 && cyc < 200) begin
      Clear = (cyc == 1);
      if (Drop === 1'b1) drop_seen = 1'b1;
      cyc++;
      @(negedge CLOCK_50);
    end
    Load = 1'b0;
    Clear = 1'b0;
    if (Drop === 1'b1) drop_seen = 1'b1;
    chk("held_busy", cyc, n + 2);
    chk("held_drop", drop_seen, 1'b0);
    model.insert(n_le(9), 9);
    chk("held_count", Count, model.size());
    check_array("held_q");
    do_clear();

    // Extremes into a 30-entry array
    for (int i = 0; i < 30; i++) do_load(DEDUP ? 8'(85 + i) : 8'd100);
    do_load(8'd0);
    do_load(8'd255);
    check_array("edge_q");

    // Randomized loads with many duplicates, running past full
    do_clear();
    repeat (40) begin
      if ($urandom_range(0, 1) == 0) do_load(8'($urandom_range(0, 15)));
      else do_load(8'($urandom));
    end
    check_array("rand_q");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
